// File: rtl/byte_word_loader_pkg.sv
// Shared types and constants for the byte-stream word loader.
// Holds the FSM state encoding and the word geometry.
// No logic; imported by the loader top and its assembler.
package byte_word_loader_pkg;

  localparam int BYTES_PER_WORD = 4;
  localparam int BYTE_IDX_W     = $clog2(BYTES_PER_WORD);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_HEADER  = 3'd1,
    S_COLLECT = 3'd2,
    S_WRITE   = 3'd3,
    S_CHECK   = 3'd4,
    S_DONE    = 3'd5
  } state_t;

endpackage

// File: rtl/byte_word_loader_asm.sv
// Little-endian byte-to-word assembler with byte-index counter.
// Latency: word_done pulses combinationally with the 4th accepted byte; word valid next cycle.
// No backpressure of its own; shifts only when shift_en is high, holds otherwise.
module byte_word_loader_asm
  import byte_word_loader_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        clear,
  input  logic        shift_en,
  input  logic [7:0]  byte_data,
  output logic [31:0] word,
  output logic        word_done
);

  logic [BYTE_IDX_W-1:0] byte_idx;

  // The byte accepted on the last slot completes the current word.
  assign word_done = shift_en && (byte_idx == BYTE_IDX_W'(BYTES_PER_WORD - 1));

  // Shift new bytes in from the top so the first byte ends up in bits [7:0].
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      byte_idx <= '0;
      word     <= '0;
    end else if (shift_en) begin
      byte_idx <= byte_idx + 1'b1;
      word     <= {byte_data, word[31:8]};
    end
  end

endmodule

// File: rtl/byte_word_loader.sv
// Loads a COUNT/payload/CHK byte frame into a word memory, one write per 4 bytes.
// Latency: mem_we fires the cycle after the 4th byte of each word is accepted.
// Backpressure: byte_ready drops in IDLE/WRITE/DONE; byte_valid low stalls indefinitely.
module byte_word_loader
  import byte_word_loader_pkg::*;
#(
  parameter int ADDR_W = 7,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic              byte_valid,
  input  logic [7:0]        byte_data,
  output logic              byte_ready,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              busy,
  output logic              done,
  output logic              error
);

  state_t            state, state_nxt;
  logic [7:0]        words_left;
  logic [ADDR_W-1:0] addr;
  logic [7:0]        chksum;
  logic              accept;
  logic              start_ok;
  logic              word_done;
  logic [31:0]       word;

  assign accept   = byte_valid && byte_ready;
  assign start_ok = (state == S_IDLE) && start && !rst;

  byte_word_loader_asm u_asm (
    .clk       (clk),
    .rst       (rst),
    .clear     (start_ok),
    .shift_en  (accept && (state == S_COLLECT)),
    .byte_data (byte_data),
    .word      (word),
    .word_done (word_done)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  // Next-state and per-state outputs; reset masks outputs in the same cycle.
  always_comb begin
    state_nxt  = state;
    byte_ready = 1'b0;
    mem_we     = 1'b0;
    done       = 1'b0;
    busy       = 1'b0;
    case (state)
      S_IDLE: begin
        if (start) state_nxt = S_HEADER;
      end
      S_HEADER: begin
        byte_ready = 1'b1;
        busy       = 1'b1;
        if (accept) state_nxt = (byte_data != 8'd0) ? S_COLLECT : S_CHECK;
      end
      S_COLLECT: begin
        byte_ready = 1'b1;
        busy       = 1'b1;
        if (word_done) state_nxt = S_WRITE;
      end
      S_WRITE: begin
        mem_we = 1'b1;
        busy   = 1'b1;
        state_nxt = (words_left == 8'd1) ? S_CHECK : S_COLLECT;
      end
      S_CHECK: begin
        byte_ready = 1'b1;
        busy       = 1'b1;
        if (accept) state_nxt = S_DONE;
      end
      S_DONE: begin
        done      = 1'b1;
        busy      = 1'b1;
        state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
    if (rst) begin
      state_nxt  = S_IDLE;
      byte_ready = 1'b0;
      mem_we     = 1'b0;
      done       = 1'b0;
      busy       = 1'b0;
    end
  end

  // Frame bookkeeping: address, remaining words, running XOR and result flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      words_left <= '0;
      addr       <= '0;
      chksum     <= '0;
      error      <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            addr   <= base_addr;
            chksum <= '0;
            error  <= 1'b0;
          end
        end
        S_HEADER: begin
          if (accept) begin
            words_left <= byte_data;
            chksum     <= chksum ^ byte_data;
          end
        end
        S_COLLECT: begin
          if (accept) chksum <= chksum ^ byte_data;
        end
        S_WRITE: begin
          words_left <= words_left - 8'd1;
          addr       <= addr + 1'b1;
        end
        S_CHECK: begin
          if (accept) error <= (byte_data != chksum);
        end
        default: ;
      endcase
    end
  end

  assign mem_addr  = addr;
  assign mem_wdata = DATA_W'(word);

endmodule

// File: tb/tb_byte_word_loader.sv
// Scoreboard bench for byte_word_loader: expected writes queued per frame, popped on mem_we.
module tb_byte_word_loader;

  typedef struct packed {
    logic [6:0]  addr;
    logic [31:0] data;
  } wr_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [6:0]  base_addr;
  logic        byte_valid;
  logic [7:0]  byte_data;
  logic        byte_ready;
  logic        mem_we;
  logic [6:0]  mem_addr;
  logic [31:0] mem_wdata;
  logic        busy;
  logic        done;
  logic        error;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  int last_acc_cyc = -10;
  int done_cnt = 0;
  wr_t exp_q[$];
  logic [7:0] pay[$];

  byte_word_loader #(.ADDR_W(7), .DATA_W(32)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .base_addr  (base_addr),
    .byte_valid (byte_valid),
    .byte_data  (byte_data),
    .byte_ready (byte_ready),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .busy       (busy),
    .done       (done),
    .error      (error)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Write monitor: every mem_we must match the head of the scoreboard.
  always @(negedge clk) begin
    if (done) done_cnt++;
    if (mem_we) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_we", 32'd1, 32'd0);
      end else begin
        wr_t e;
        e = exp_q.pop_front();
        chk("wr_addr", 32'(mem_addr), 32'(e.addr));
        chk("wr_data", mem_wdata, e.data);
        chk("wr_latency", 32'(cyc), 32'(last_acc_cyc));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b, input bit gaps, input bit is_payload);
    bit ok;
    int n;
    ok = 1'b0;
    n  = 0;
    if (gaps) repeat ($urandom_range(0, 3)) tick();
    byte_valid = 1'b1;
    byte_data  = b;
    do begin
      @(negedge clk);
      ok = byte_ready;
      tick();
      n++;
    end while (!ok && n < 50);
    byte_valid = 1'b0;
    byte_data  = $urandom_range(0, 255);
    if (!ok) chk("byte_timeout", 32'd0, 32'd1);
    else if (is_payload) last_acc_cyc = cyc;
  endtask

  task automatic pulse_start(input logic [6:0] base);
    start     = 1'b1;
    base_addr = base;
    tick();
    start     = 1'b0;
    base_addr = $urandom_range(0, 127);
  endtask

  // Drives one frame from pay[], queues its writes and checks done/error.
  task automatic run_frame(input logic [6:0] base, input bit gaps, input bit mid_start,
                           input bit corrupt);
    int nw;
    int d0;
    int n;
    logic [7:0] x;
    bit seen;
    nw = pay.size() / 4;
    x  = 8'(nw);
    for (int w = 0; w < nw; w++) begin
      wr_t e;
      e.addr = 7'(base + w);
      e.data = {pay[4*w+3], pay[4*w+2], pay[4*w+1], pay[4*w]};
      exp_q.push_back(e);
    end
    foreach (pay[i]) x ^= pay[i];
    d0 = done_cnt;
    pulse_start(base);
    chk("err_cleared_on_start", 32'(error), 32'd0);
    chk("busy_after_start", 32'(busy), 32'd1);
    send_byte(8'(nw), gaps, 1'b0);
    foreach (pay[i]) begin
      if (mid_start && i == 2) begin
        start     = 1'b1;
        base_addr = 7'd99;
      end
      send_byte(pay[i], gaps, 1'b1);
      start = 1'b0;
    end
    send_byte(x ^ {7'd0, corrupt}, gaps, 1'b0);
    seen = 1'b0;
    n = 0;
    while (!seen && n < 20) begin
      @(negedge clk);
      seen = done;
      if (!seen) tick();
      n++;
    end
    chk("done_seen", 32'(seen), 32'd1);
    chk("error_flag", 32'(error), 32'(corrupt));
    tick();
    @(negedge clk);
    chk("done_one_cycle", 32'(done), 32'd0);
    chk("idle_after_done", 32'(busy), 32'd0);
    chk("done_count", 32'(done_cnt - d0), 32'd1);
    chk("writes_drained", 32'(exp_q.size()), 32'd0);
    exp_q.delete();
    tick();
  endtask

  initial begin
    logic [7:0] base_pay[8];
    base_pay = '{8'h11, 8'h22, 8'h33, 8'h44, 8'hAA, 8'hBB, 8'hCC, 8'hDD};
    rst = 1'b1; start = 1'b0; base_addr = '0; byte_valid = 1'b0; byte_data = '0;
    repeat (3) tick();
    @(negedge clk);
    chk("rst_byte_ready", 32'(byte_ready), 32'd0);
    chk("rst_mem_we", 32'(mem_we), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_error", 32'(error), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    tick();
    rst = 1'b0;
    tick();
    @(negedge clk);
    chk("idle_ready_low", 32'(byte_ready), 32'd0);
    tick();

    // Basic two-word frame at base 5.
    pay.delete();
    foreach (base_pay[i]) pay.push_back(base_pay[i]);
    run_frame(7'd5, 1'b0, 1'b0, 1'b0);

    // Same frame with a corrupted checksum; error must hold until next start.
    run_frame(7'd5, 1'b0, 1'b0, 1'b1);
    repeat (5) tick();
    @(negedge clk);
    chk("error_held", 32'(error), 32'd1);
    tick();

    // Address wrap: 126, 127, 0.
    pay.delete();
    for (int i = 0; i < 12; i++) pay.push_back(8'($urandom_range(0, 255)));
    run_frame(7'd126, 1'b0, 1'b0, 1'b0);

    // Empty frames.
    pay.delete();
    run_frame(7'd40, 1'b0, 1'b0, 1'b0);
    run_frame(7'd40, 1'b0, 1'b0, 1'b1);

    // Gaps on byte_valid plus a start pulse while busy.
    pay.delete();
    foreach (base_pay[i]) pay.push_back(base_pay[i]);
    run_frame(7'd5, 1'b1, 1'b1, 1'b0);
    pay.delete();
    for (int i = 0; i < 16; i++) pay.push_back(8'($urandom_range(0, 255)));
    run_frame(7'd70, 1'b1, 1'b0, 1'b0);

    // Reset after two payload bytes: no write, no done.
    begin
      int d0;
      d0 = done_cnt;
      pulse_start(7'd10);
      send_byte(8'd2, 1'b0, 1'b0);
      send_byte(8'h01, 1'b0, 1'b1);
      send_byte(8'h02, 1'b0, 1'b1);
      rst = 1'b1;
      @(negedge clk);
      chk("midrst_ready", 32'(byte_ready), 32'd0);
      tick();
      @(negedge clk);
      chk("midrst_busy", 32'(busy), 32'd0);
      chk("midrst_error", 32'(error), 32'd0);
      tick();
      rst = 1'b0;
      byte_valid = 1'b1;
      byte_data  = 8'h03;
      repeat (6) tick();
      byte_valid = 1'b0;
      chk("midrst_no_done", 32'(done_cnt - d0), 32'd0);
      chk("midrst_idle", 32'(busy), 32'd0);
    end
    pay.delete();
    foreach (base_pay[i]) pay.push_back(base_pay[i]);
    run_frame(7'd10, 1'b0, 1'b0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/byte_word_loader.md
BYTE_WORD_LOADER -- requirements
Module: byte_word_loader

Interface
REQ-001 Parameter ADDR_W, default 7, word-address width of the target memory.
REQ-002 Parameter DATA_W, default 32, target word width; fixed at 32 (4 bytes per word).
REQ-003 clk  input  1  single clock; all state changes on its rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 start  input  1  one-cycle request to begin a load frame.
REQ-006 base_addr  input  ADDR_W  first word address of the frame; sampled on an accepted start.
REQ-007 byte_valid  input  1  byte_data holds a valid stream byte.
REQ-008 byte_data  input  8  stream byte.
REQ-009 byte_ready  output  1  loader can accept a byte this cycle.
REQ-010 mem_we  output  1  one-cycle write strobe to target memory.
REQ-011 mem_addr  output  ADDR_W  write word address.
REQ-012 mem_wdata  output  32  assembled write word.
REQ-013 busy  output  1  high in any state other than IDLE.
REQ-014 done  output  1  one-cycle pulse at frame end.
REQ-015 error  output  1  checksum mismatch of the last frame; held until the next accepted start or reset.

Function
REQ-016 Frame format: COUNT byte (N words, 0..255), then 4*N payload bytes, then one CHK byte.
REQ-017 A byte is accepted only in a cycle where byte_valid and byte_ready are both high.
REQ-018 States: IDLE, HEADER, COLLECT, WRITE, CHECK, DONE.
REQ-019 IDLE: byte_ready=0; start=1 latches base_addr, clears error and checksum, and moves to HEADER next cycle.
REQ-020 start is ignored in every state other than IDLE.
REQ-021 HEADER: byte_ready=1; accepted byte loads the word counter; moves to COLLECT if N>0, else to CHECK.
REQ-022 COLLECT: byte_ready=1; bytes are assembled little-endian, so the first byte lands in bits [7:0] and the fourth in [31:24]; after the fourth accepted byte, moves to WRITE.
REQ-023 WRITE: byte_ready=0; mem_we=1 for exactly one cycle, with mem_addr = base_addr + word index mod 2^ADDR_W and mem_wdata = the assembled word.
REQ-024 After WRITE, the next state is COLLECT if words remain, else CHECK.
REQ-025 Latency: the mem_we cycle is the cycle immediately after the fourth byte of the word is accepted.
REQ-026 Checksum: running XOR of the COUNT byte and all payload bytes.
REQ-027 CHECK: byte_ready=1; on the accepted CHK byte, error is set to 1 if CHK differs from the running XOR, else 0; moves to DONE.
REQ-028 DONE: byte_ready=0; done=1 for one cycle; returns to IDLE.
REQ-029 Address wraps modulo 2^ADDR_W with no error; for example, base 126 with N=3 writes 126, 127, 0.
REQ-030 byte_valid low stalls the loader indefinitely in HEADER/COLLECT/CHECK with no timeout; assembled bytes are retained.
REQ-031 Data already written before a checksum failure is not rolled back.
REQ-032 mem_addr and mem_wdata are don't-care when mem_we=0; a bench checks them only while mem_we=1.

Reset
REQ-033 rst=1 forces state IDLE and clears byte_ready, mem_we, done, error, busy, word counter, byte index and checksum; it takes priority over start and byte handshakes.
REQ-034 Reset mid-frame aborts the frame with no further mem_we and no done pulse.

Structure
REQ-035 A shared package holds the state enum and the constant BYTES_PER_WORD=4.
REQ-036 One sub-module, byte_word_loader_asm, performs byte-index counting and little-endian shift-in; the FSM, counters and checksum stay in the top module.

Verification
REQ-037 Scenario: base=5; stream 02, 11 22 33 44, AA BB CC DD, CHK=02^11^22^33^44^AA^BB^CC^DD -> writes 0x44332211@5 and 0xDDCCBBAA@6; done pulse; error=0.
REQ-038 Scenario: same frame with CHK corrupted by XOR 0x01 -> both writes occur; done pulse; error=1 held until the next start.
REQ-039 Scenario: base=126, N=3, any payload -> mem_we at addresses 126, 127, 0 in order.
REQ-040 Scenario: N=0 with CHK=00 -> no mem_we; done pulse; error=0. N=0 with CHK=01 -> error=1.
REQ-041 Scenario: random byte_valid gaps, plus start pulsed while busy -> identical writes to the gap-free run; the mid-frame start has no effect.
REQ-042 Scenario: rst asserted after 2 payload bytes of word 0 -> no mem_we and no done; after release, a fresh frame completes correctly.
